// File: rtl/sap_control_sequencer.sv
// SAP-style micro-sequencer: accepts 3-bit opcodes over valid/ready and issues
// the per-T-state datapath strobes, with a zero-flag conditional skip and bus ownership.
module sap_control_sequencer #(
  parameter bit ALLOW_SKZ = 1'b1,
  parameter int OUT_HOLD  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [2:0] instr_opcode,
  output logic       instr_ready,
  input  logic       zf_in,
  input  logic       cf_in,
  output logic       nLa,
  output logic       Ea,
  output logic       nLb,
  output logic       Eu,
  output logic       sub,
  output logic       nLo,
  output logic       ext_en,
  output logic       halted,
  output logic       busy,
  output logic       cf_lat
);

  if (OUT_HOLD < 1 || OUT_HOLD > 4) begin : g_bad_out_hold
    $error("sap_control_sequencer: OUT_HOLD must be in 1..4");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_T2 = 2'd1, S_T3 = 2'd2, S_HALT = 2'd3} state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OUT = 3'd4;
  localparam logic [2:0] OP_DBL = 3'd5;
  localparam logic [2:0] OP_SKZ = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  localparam logic [1:0] HOLD_INIT = 2'(OUT_HOLD - 1);
  // Strobe vector order: {nLa, Ea, nLb, Eu, sub, nLo, ext_en}
  localparam logic [6:0] STB_IDLE  = 7'b1010010;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic       r_skip, w_skip_nxt;
  logic [1:0] r_hold, w_hold_nxt;
  logic       r_cf, w_cf_nxt;
  logic       r_halted;
  logic       r_busy;
  logic [6:0] r_stb, w_stb_nxt;
  logic       w_accept;

  // Strobes owned by a given T-state of a given opcode
  function automatic logic [6:0] stb_decode(input state_t st, input logic [2:0] op);
    logic [6:0] v;
    v = STB_IDLE;
    if (st == S_T2) begin
      case (op)
        OP_LDA:         v = 7'b0010011;
        OP_ADD, OP_SUB: v = 7'b1000011;
        OP_OUT:         v = 7'b1110000;
        OP_DBL:         v = 7'b1100010;
        default:        v = STB_IDLE;
      endcase
    end else if (st == S_T3) begin
      case (op)
        OP_ADD, OP_DBL: v = 7'b0011010;
        OP_SUB:         v = 7'b0011110;
        default:        v = STB_IDLE;
      endcase
    end else begin
      v = STB_IDLE;
    end
    return v;
  endfunction

  assign instr_ready = rst_n && (r_state == S_IDLE);
  assign w_accept    = instr_valid && instr_ready;

  // Next-state, latched opcode, skip/hold/carry updates and registered strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_skip_nxt  = r_skip;
    w_hold_nxt  = r_hold;
    w_cf_nxt    = r_cf;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt = instr_opcode;
          if (r_skip) begin
            w_skip_nxt = 1'b0;
          end else begin
            case (instr_opcode)
              OP_NOP:                         w_state_nxt = S_IDLE;
              OP_LDA, OP_ADD, OP_SUB, OP_DBL: w_state_nxt = S_T2;
              OP_OUT: begin
                w_state_nxt = S_T2;
                w_hold_nxt  = HOLD_INIT;
              end
              OP_SKZ:  w_state_nxt = ALLOW_SKZ ? S_T2 : S_IDLE;
              OP_HLT:  w_state_nxt = S_HALT;
              default: w_state_nxt = S_IDLE;
            endcase
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_T2: begin
        case (r_op)
          OP_ADD, OP_SUB, OP_DBL: w_state_nxt = S_T3;
          OP_OUT: begin
            if (r_hold != 2'd0) begin
              w_hold_nxt  = r_hold - 2'd1;
              w_state_nxt = S_T2;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          OP_SKZ: begin
            w_skip_nxt  = zf_in;
            w_state_nxt = S_IDLE;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
      S_T3: begin
        w_state_nxt = S_IDLE;
        if (r_op == OP_ADD || r_op == OP_SUB) begin
          w_cf_nxt = cf_in;
        end else begin
          w_cf_nxt = r_cf;
        end
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
    w_stb_nxt = stb_decode(w_state_nxt, w_op_nxt);
  end

  // State and registered control outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_skip   <= 1'b0;
      r_hold   <= 2'd0;
      r_cf     <= 1'b0;
      r_halted <= 1'b0;
      r_busy   <= 1'b0;
      r_stb    <= STB_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_skip   <= w_skip_nxt;
      r_hold   <= w_hold_nxt;
      r_cf     <= w_cf_nxt;
      r_halted <= (w_state_nxt == S_HALT);
      r_busy   <= (w_state_nxt == S_T2) || (w_state_nxt == S_T3);
      r_stb    <= w_stb_nxt;
    end
  end

  assign {nLa, Ea, nLb, Eu, sub, nLo, ext_en} = r_stb;
  assign halted = r_halted;
  assign busy   = r_busy;
  assign cf_lat = r_cf;

  sap_control_sequencer_bus_chk u_bus_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .ext_en (ext_en),
    .ea     (Ea),
    .eu     (Eu)
  );

endmodule

// Bus ownership checker: never more than one bus driver enabled in a cycle.
module sap_control_sequencer_bus_chk (
  input logic clk,
  input logic rst_n,
  input logic ext_en,
  input logic ea,
  input logic eu
);

  a_one_bus_driver: assert property (@(posedge clk) disable iff (!rst_n)
    !((ext_en && ea) || (ext_en && eu) || (ea && eu)))
    else $error("more than one bus driver enabled");

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: a per-cycle schedule model of the
// expected strobes, checked every cycle, plus literal expectations at key points.
module tb_sap_control_sequencer;

  localparam int HOLD = 2;
  localparam logic [6:0] IDLE_VEC = 7'b1010010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [2:0] instr_opcode = 3'd0;
  logic       zf_in = 1'b0;
  logic       cf_in = 1'b0;
  logic       instr_ready, nLa, Ea, nLb, Eu, sub, nLo, ext_en, halted, busy, cf_lat;
  logic [6:0] w_vec;

  sap_control_sequencer #(.ALLOW_SKZ(1'b1), .OUT_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
    .instr_ready(instr_ready), .zf_in(zf_in), .cf_in(cf_in),
    .nLa(nLa), .Ea(Ea), .nLb(nLb), .Eu(Eu), .sub(sub), .nLo(nLo), .ext_en(ext_en),
    .halted(halted), .busy(busy), .cf_lat(cf_lat)
  );

  assign w_vec = {nLa, Ea, nLb, Eu, sub, nLo, ext_en};

  initial forever #5 clk = ~clk;

  // Each entry is what one cycle must look like: strobes plus which flag it samples.
  typedef struct packed {
    logic [6:0] vec;
    logic       busy;
    logic       szf;
    logic       scf;
  } ent_t;

  ent_t m_cur;
  ent_t m_q[$];
  logic m_skip = 1'b0, m_halted = 1'b0, m_cf = 1'b0;
  int   n_cmp = 0, n_err = 0;
  bit   chk_en = 1'b0;

  function automatic ent_t ent(input logic [6:0] v, input logic b, input logic z, input logic c);
    ent_t e;
    e.vec = v; e.busy = b; e.szf = z; e.scf = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs held for that cycle.
  task automatic model_edge();
    logic acc;
    if (!rst_n) begin
      m_q.delete();
      m_cur = ent(IDLE_VEC, 1'b0, 1'b0, 1'b0);
      m_skip = 1'b0; m_halted = 1'b0; m_cf = 1'b0;
    end else begin
      if (m_cur.szf) m_skip = zf_in;
      if (m_cur.scf) m_cf = cf_in;
      acc = instr_valid && !m_halted && !m_cur.busy;
      if (acc) begin
        if (m_skip) begin
          m_skip = 1'b0;
        end else begin
          case (instr_opcode)
            3'd1: m_q.push_back(ent(7'b0010011, 1'b1, 1'b0, 1'b0));
            3'd2: begin
              m_q.push_back(ent(7'b1000011, 1'b1, 1'b0, 1'b0));
              m_q.push_back(ent(7'b0011010, 1'b1, 1'b0, 1'b1));
            end
            3'd3: begin
              m_q.push_back(ent(7'b1000011, 1'b1, 1'b0, 1'b0));
              m_q.push_back(ent(7'b0011110, 1'b1, 1'b0, 1'b1));
            end
            3'd4: for (int i = 0; i < HOLD; i++) m_q.push_back(ent(7'b1110000, 1'b1, 1'b0, 1'b0));
            3'd5: begin
              m_q.push_back(ent(7'b1100010, 1'b1, 1'b0, 1'b0));
              m_q.push_back(ent(7'b0011010, 1'b1, 1'b0, 1'b0));
            end
            3'd6: m_q.push_back(ent(IDLE_VEC, 1'b1, 1'b1, 1'b0));
            3'd7: m_halted = 1'b1;
            default: ;
          endcase
        end
      end
      m_cur = (m_q.size() > 0) ? m_q.pop_front() : ent(IDLE_VEC, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic z, input logic c);
    instr_valid = v; instr_opcode = op; zf_in = z; cf_in = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Every-cycle comparison against the model, away from the rising edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("strobes", 32'(w_vec), 32'(m_cur.vec));
      chk("busy", 32'(busy), 32'(m_cur.busy));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("cf_lat", 32'(cf_lat), 32'(m_cf));
      chk("ready", 32'(instr_ready), 32'(rst_n && !m_halted && !m_cur.busy));
      chk("bus_one_driver", 32'((int'(ext_en) + int'(Ea) + int'(Eu)) <= 1), 32'd1);
    end
  end

  initial begin
    int cnt;
    m_cur = ent(IDLE_VEC, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("rst_vec", 32'(w_vec), 32'h52);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);

    // ADD with carry captured at the end of T3
    step(1'b1, 3'd2, 1'b0, 1'b0);
    chk("add_t2", 32'(w_vec), 32'h43);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("add_t3", 32'(w_vec), 32'h1a);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    chk("add_cf", 32'(cf_lat), 32'd1);
    chk("add_ready", 32'(instr_ready), 32'd1);

    // SUB, then OUT held for HOLD cycles
    step(1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("sub_t3", 32'(w_vec), 32'h1e);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (Ea && !nLo) cnt++;
      step(1'b0, 3'd0, 1'b0, 1'b0);
    end
    chk("out_hold_cycles", 32'(cnt), 32'd2);

    // SKZ with zf=1 skips the following LDA
    step(1'b1, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("skip_lda_vec", 32'(w_vec), 32'h52);
    chk("skip_lda_ready", 32'(instr_ready), 32'd1);

    // SKZ with zf=0 leaves LDA alone
    step(1'b1, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("lda_vec", 32'(w_vec), 32'h13);
    step(1'b0, 3'd0, 1'b0, 1'b0);

    // A skipped HLT does not halt
    step(1'b1, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd7, 1'b0, 1'b0);
    chk("skip_hlt", 32'(halted), 32'd0);

    // A skipped SKZ does not re-arm, so DBL executes
    step(1'b1, 3'd6, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 3'd6, 1'b1, 1'b0);
    step(1'b1, 3'd5, 1'b1, 1'b0);
    chk("dbl_t2", 32'(w_vec), 32'h62);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("dbl_t3", 32'(w_vec), 32'h1a);
    step(1'b0, 3'd0, 1'b0, 1'b0);

    // Mixed traffic, HLT excluded
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b0, 1'b0);

    // Reset in the middle of ADD T2
    step(1'b1, 3'd2, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("rst_mid_vec", 32'(w_vec), 32'h52);
    chk("rst_mid_ready", 32'(instr_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(instr_ready), 32'd1);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    chk("rst_no_t3", 32'(w_vec), 32'h52);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'd0, 1'b0, 1'b0);
      chk("nop_ready", 32'(instr_ready), 32'd1);
    end

    // HLT holds off all traffic until reset
    step(1'b1, 3'd7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_ready", 32'(instr_ready), 32'd0);
    rst_n = 1'b0;
    step(1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("hlt_rst_halted", 32'(halted), 32'd0);
    chk("hlt_rst_ready", 32'(instr_ready), 32'd1);
    step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("post_hlt_lda", 32'(w_vec), 32'h13);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Micro-sequencer sitting directly upstream of the adder/accumulator datapath.
- Accepts 3-bit instructions over a valid/ready handshake and issues the datapath control strobes for each T-state: accumulator load/enable, B load, ALU enable/subtract, output-register load, external-bus drive.
- Reads the ALU zero flag to implement a conditional skip.
- Owns bus arbitration: at most one bus driver is enabled per cycle.

Parameters:
- ALLOW_SKZ, 1, when 0 opcode 110 decodes as NOP.
- OUT_HOLD, 1, cycles (1..4) that nLo is held low for OUT; T2 is repeated OUT_HOLD times.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  opcode present
- instr_opcode  in  3  instruction
- instr_ready  out  1  sequencer can accept an instruction this cycle
- zf_in  in  1  ALU zero flag
- cf_in  in  1  ALU carry flag, latched only, for debug
- nLa  out  1  accumulator load, active low
- Ea  out  1  accumulator drives bus
- nLb  out  1  B register load, active low
- Eu  out  1  ALU drives bus
- sub  out  1  ALU subtract select
- nLo  out  1  output register load, active low
- ext_en  out  1  external input drives bus
- halted  out  1  HLT executed
- busy  out  1  in T2/T3
- cf_lat  out  1  cf_in captured at end of each ADD/SUB T3

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- States: IDLE, T2, T3, HALT. Accept occurs when instr_valid && instr_ready; the opcode is latched into op_r on accept.
- instr_ready = 1 only in IDLE, and only when not in reset.
- Control outputs are registered and decoded from the next state/op. Each strobe is asserted exactly during the cycle the FSM occupies that T-state.
- Default (IDLE/HALT): nLa=nLb=nLo=1; Ea=Eu=sub=ext_en=0.
- Opcode decode:
  - 000 NOP: no T-states; stays IDLE; back-to-back accepts allowed every cycle.
  - 001 LDA: T2: ext_en=1, nLa=0. Then IDLE.
  - 010 ADD: T2: ext_en=1, nLb=0. T3: Eu=1, sub=0, nLa=0. Then IDLE.
  - 011 SUB: as ADD but sub=1 in T3. sub is 0 in T2.
  - 100 OUT: T2 repeated OUT_HOLD cycles: Ea=1, nLo=0. Then IDLE.
  - 101 DBL: T2: Ea=1, nLb=0. T3: Eu=1, nLa=0. Then IDLE.
  - 110 SKZ: T2: samples zf_in; skip_r <= zf_in. No strobes. Then IDLE.
  - 111 HLT: goes to HALT; halted=1, instr_ready=0 until reset.
- Skip: if skip_r=1, the next accepted instruction executes as NOP (no T-states) and clears skip_r. A skipped HLT does not halt. A skipped SKZ does not re-arm skip_r.
- Latency: accept in cycle N; T2 strobes in N+1; T3 in N+2. instr_ready returns in N+2 (1-state op) or N+3 (2-state op).
- Bus rule (assertion): ext_en+Ea+Eu <= 1 every cycle.
- busy = (state==T2 || state==T3).
- cf_lat updates at the end of T3 of ADD/SUB only; unchanged otherwise.
- Reset (rst_n=0 at a clock edge), including mid-instruction:
  - Next cycle: IDLE, all strobes at default, skip_r=0, halted=0, cf_lat=0, op_r=0.
  - instr_ready=0 while rst_n=0, and 1 on the first cycle after release.
- instr_valid while not ready: ignored; the opcode is not latched. The upstream must hold it.
- Illegal OUT_HOLD values (0 or >4): elaboration error.

Test Plan:
- Reset, then idle → instr_ready=1, nLa=nLb=nLo=1, Ea=Eu=sub=ext_en=0, halted=0.
- Accept ADD (010) at cycle N → N+1: ext_en=1, nLb=0; N+2: Eu=1, nLa=0, sub=0; N+3: instr_ready=1. cf_in=1 at N+2 gives cf_lat=1.
- Accept SUB, then OUT with OUT_HOLD=2 → sub=1 only in SUB T3; Ea=1, nLo=0 for exactly 2 cycles; bus-rule assertion never fires.
- SKZ with zf_in=1, then LDA → LDA produces no strobes, skip_r cleared. Repeat with zf_in=0 → LDA gives ext_en=1, nLa=0 for one cycle.
- HLT → halted=1, instr_ready=0 for 20 cycles with instr_valid=1. Then rst_n=0 for one edge → IDLE, halted=0.
- rst_n low during ADD T2 → next cycle all strobes default, no T3 issued; NOP stream afterward is accepted every cycle.
